// File: rtl/debug_ocimem_sequencer.sv
// JTAG debug command sequencer driving the OCI debug memory request/ack handshake.
// Optional mem_ack timeout enabled by defining DEBUG_OCIMEM_TIMEOUT_EN.
module debug_ocimem_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_data,
    output logic              cmd_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       mon_dreg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic              we_q;
    logic [31:0]       data_q;
    logic              expire;

`ifdef DEBUG_OCIMEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;

    // cnt holds the number of WAIT cycles already elapsed; this cycle is the last allowed one
    assign expire = (state == S_WAIT) && !mem_ack && (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset)                 cnt <= '0;
        else if (state == S_IDLE)  cnt <= '0;
        else if (state == S_WAIT)  cnt <= cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign expire = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign mem_req   = (state == S_ISSUE) || (state == S_WAIT);
    assign mem_we    = we_q;
    assign mem_addr  = addr;
    assign mem_wdata = data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            addr          <= '0;
            we_q          <= 1'b0;
            data_q        <= '0;
            mon_dreg      <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            2'b00: begin
                                addr          <= cmd_data[ADDR_W-1:0];
                                monitor_ready <= 1'b1;
                                monitor_error <= 1'b0;
                            end
                            2'b11: begin
                                monitor_ready <= 1'b0;
                                monitor_error <= 1'b0;
                            end
                            default: begin
                                we_q          <= (cmd_op == 2'b01);
                                data_q        <= cmd_data;
                                monitor_ready <= 1'b0;
                                monitor_error <= 1'b0;
                                state         <= S_ISSUE;
                            end
                        endcase
                    end
                end
                S_ISSUE, S_WAIT: begin
                    // ack is honoured in ISSUE too, so zero-wait memories finish in 3 cycles
                    if (mem_ack) begin
                        if (!we_q) mon_dreg <= mem_rdata;
                        addr  <= addr + 1'b1;
                        state <= S_DONE;
                    end else if (expire) begin
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                default: begin
                    monitor_ready <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_ocimem_sequencer.sv
// Directed bench for debug_ocimem_sequencer: transaction-timeline model plus per-cycle compare.
module tb_debug_ocimem_sequencer;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [31:0]   cmd_data;
    logic          cmd_ready;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata, mon_dreg;
    logic          mem_ack, monitor_ready, monitor_error;

    debug_ocimem_sequencer #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mon_dreg(mon_dreg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    // model state and expected outputs for the current cycle
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_dreg = '0;
    logic          e_cmd = 1, e_req = 0, e_we = 0, e_rdy = 0, e_err = 0;
    logic [AW-1:0] e_addr = '0;
    logic [31:0]   e_wdata = '0;
    logic [AW-1:0] last_issue_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", 32'(cmd_ready), 32'(e_cmd));
            check("mem_req", 32'(mem_req), 32'(e_req));
            check("mon_dreg", mon_dreg, m_dreg);
            check("monitor_ready", 32'(monitor_ready), 32'(e_rdy));
            check("monitor_error", 32'(monitor_error), 32'(e_err));
            if (e_req) begin
                check("mem_we", 32'(mem_we), 32'(e_we));
                check("mem_addr", 32'(mem_addr), 32'(e_addr));
                check("mem_wdata", mem_wdata, e_wdata);
            end
        end
    end

    task automatic set_addr(input logic [31:0] a);
        cmd_valid = 1; cmd_op = 2'b00; cmd_data = a;
        step();
        cmd_valid = 0;
        m_addr = a[AW-1:0]; e_rdy = 1; e_err = 0;
    endtask

    task automatic clear_status();
        cmd_valid = 1; cmd_op = 2'b11; cmd_data = 32'hFFFF_FFFF;
        step();
        cmd_valid = 0;
        e_rdy = 0; e_err = 0;
    endtask

    // lat = WAIT cycles before ack (0: ack in ISSUE, <0: never ack); drop = strobe a write in WAIT1
    task automatic access(input logic we, input logic [31:0] d, input logic [31:0] rd,
                          input int lat, input bit drop);
        cmd_valid = 1; cmd_op = we ? 2'b01 : 2'b10; cmd_data = d;
        step();
        last_issue_addr = mem_addr;
        cmd_valid = 0;
        e_cmd = 0; e_req = 1; e_we = we; e_addr = m_addr; e_wdata = d; e_rdy = 0; e_err = 0;
        mem_ack = (lat == 0); mem_rdata = rd;
        for (int i = 1; i <= ((lat < 0) ? TO : lat); i++) begin
            step();
            mem_ack = (i == lat);
            cmd_valid = drop && (i == 1); cmd_op = 2'b01; cmd_data = 32'hBAD0_BAD0;
        end
        step();
        mem_ack = 0; cmd_valid = 0; mem_rdata = 32'h0BAD_0BAD;
        if (lat >= 0) begin
            if (!we) m_dreg = rd;
            m_addr = m_addr + 1'b1;
            e_req = 0; e_cmd = 0;
            step();
            e_cmd = 1; e_rdy = 1;
        end else begin
            e_req = 0; e_cmd = 1; e_rdy = 1; e_err = 1;
        end
    endtask

    initial begin
        reset = 1; cmd_valid = 0; cmd_op = 0; cmd_data = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mon_dreg", mon_dreg, 32'd0);
        check("rst_monitor_ready", 32'(monitor_ready), 32'd0);
        check("rst_monitor_error", 32'(monitor_error), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 0; chk_en = 1;
        step();

        set_addr(32'h0000_0010);
        access(1'b1, 32'hDEAD_BEEF, 32'h0, 2, 1'b0);
        check("wr_issue_addr", 32'(last_issue_addr), 32'h10);
        check("wr_monitor_ready", 32'(monitor_ready), 32'd1);
        check("wr_keeps_dreg", mon_dreg, 32'd0);
        access(1'b0, 32'h0, 32'hA5A5_5A5A, 1, 1'b0);
        check("rd_issue_addr", 32'(last_issue_addr), 32'h11);

        set_addr(32'hFFFF_FFFF);
        access(1'b0, 32'h0, 32'h1234_5678, 0, 1'b0);
        check("rd_ff_dreg", mon_dreg, 32'h1234_5678);
        access(1'b1, 32'h0000_0001, 32'h0, 1, 1'b0);
        check("wrap_addr", 32'(last_issue_addr), 32'h00);

        clear_status();
        step();
        check("clr_ready", 32'(monitor_ready), 32'd0);

        set_addr(32'h40);
        access(1'b0, 32'h0, 32'h0000_C0DE, 3, 1'b1);
        step();
        access(1'b0, 32'h0, 32'h0000_0042, 0, 1'b0);
        check("drop_addr", 32'(last_issue_addr), 32'h41);

        cmd_valid = 1; cmd_op = 2'b10; cmd_data = 0;
        step();
        cmd_valid = 0;
        e_cmd = 0; e_req = 1; e_we = 0; e_addr = m_addr; e_rdy = 0; e_err = 0;
        step();
        reset = 1;
        step();
        reset = 0; mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        m_dreg = 0; m_addr = 0; e_req = 0; e_cmd = 1; e_rdy = 0; e_err = 0;
        step();
        mem_ack = 0;
        step();
        check("late_ack_dreg", mon_dreg, 32'd0);
        access(1'b0, 32'h0, 32'h7777_0000, 1, 1'b0);
        check("post_rst_addr", 32'(last_issue_addr), 32'h00);

`ifdef DEBUG_OCIMEM_TIMEOUT_EN
        set_addr(32'h20);
        access(1'b0, 32'h0, 32'h0, -1, 1'b0);
        check("to_error", 32'(monitor_error), 32'd1);
        check("to_ready", 32'(monitor_ready), 32'd1);
        step();
        access(1'b0, 32'h0, 32'h5555_AAAA, TO, 1'b0);
        check("to_addr_kept", 32'(last_issue_addr), 32'h20);
        check("ack_wins_error", 32'(monitor_error), 32'd0);
`endif
        step();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
